wb_ram_model: RTL and testbench
===============================

// Module: wb_ram_model
// PURPOSE
//  Pipelined Wishbone (B4 pipelined) slave memory model; the bus target that
//  bench masters drive.  Accepts one request per clock, returns ACK or ERR a
//  fixed LATENCY cycles later, and optionally inserts pseudo-random stalls.
//  Exercises master-side pipelining, outstanding-request counting and error
//  abort paths.
// PARAMETERS
//  AW        5        word-address width
//  DW        32       data width; must be a multiple of 8
//  MEMWORDS  24       implemented words; word address >= MEMWORDS returns ERR
//  LATENCY   2        cycles from accepted request to ACK/ERR; legal 1..8
//  OPT_STALL 1'b1     1: stall driven by LFSR; 0: o_wb_stall held 0
// PORTS
//  i_clk       in   1      clock
//  i_reset_n   in   1      asynchronous reset, active low
//  i_wb_cyc    in   1      bus cycle
//  i_wb_stb    in   1      request strobe
//  i_wb_we     in   1      1=write, 0=read
//  i_wb_addr   in   AW     word address
//  i_wb_data   in   DW     write data
//  i_wb_sel    in   DW/8   byte-lane enables for writes
//  o_wb_stall  out  1      request not accepted this cycle
//  o_wb_ack    out  1      one-cycle success response
//  o_wb_data   out  DW     read data; valid with o_wb_ack on reads, else 0
//  o_wb_err    out  1      one-cycle error response
// BEHAVIOUR
//  Reset: one clock domain; i_reset_n is asynchronous and active-low.  While
//   low: o_wb_stall=0, o_wb_ack=0, o_wb_err=0, o_wb_data=0, all pipeline
//   valid bits=0, LFSR=16'hACE1.  Memory contents are not reset.
//  Accept: accept = i_wb_cyc & i_wb_stb & !o_wb_stall.
//  Stall: 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every clock.
//   - o_wb_stall is registered: OPT_STALL & lfsr[0] & lfsr[1] (~25% duty).
//   - OPT_STALL=0: o_wb_stall constant 0.
//  Request handling, on the accept edge:
//   - Compute err = (i_wb_addr >= MEMWORDS).
//   - Write with err=0: each byte lane k with i_wb_sel[k]=1 is updated.
//   - Read with err=0: the addressed word is captured at accept.
//   - Read-after-write in a back-to-back burst therefore returns the new data.
//   - err=1: memory is untouched.
//  Pipeline: LATENCY-stage shift register of {valid, we, err, rdata}.
//   - Stage 0 loads on accept; valid=0 otherwise.
//   - The final stage drives the registered outputs:
//     o_wb_ack = v & !err;  o_wb_err = v & err;
//     o_wb_data = (v & !we & !err) ? rdata : 0.
//   - A request accepted on edge N produces its response high after edge
//     N+LATENCY, for exactly one cycle.
//   - Throughput is one response per cycle; the pipeline never backs up.
//  Abort: while i_wb_cyc=0, all valid bits clear on the next edge.
//   - o_wb_ack and o_wb_err are forced 0 whenever i_wb_cyc was 0 on the
//     previous edge.
//   - Writes already committed stay committed.
//  Simultaneous events: an accept in the same cycle as a final-stage response
//   is legal; both occur.  If i_wb_cyc drops in the same cycle as a
//   response, the response is still presented.
//  Stall with stb high: no accept and no memory access; the master holds its
//   request.
//  o_wb_ack and o_wb_err are never both high.
//  Response count always equals the number of accepts (abort excepted).
// TESTING
//  1. OPT_STALL=0, LATENCY=2: write 0x1234_5678 @3 (sel 4'hf), then read @3
//     -> write ACK 2 cycles after accept; read ACK with data 0x1234_5678.
//  2. Byte lanes: write 0xFFFF_FFFF @5, then write 0x0000_00AA sel 4'b0001,
//     then read @5 -> 0xFFFF_FFAA.
//  3. Burst: 8 back-to-back reads @0..7, no stall -> 8 consecutive ACKs, in
//     order, with no gaps; the first ACK comes LATENCY cycles after the first
//     accept.
//  4. Out-of-range write @25 (MEMWORDS=24) -> o_wb_err pulses once, no ACK;
//     subsequent read @25 also ERRs; memory @1 (=25 mod 24) is unchanged.
//  5. OPT_STALL=1: 64-request random read/write burst -> responses equal
//     accepts, data matches a scoreboard, no request is lost while stalled.
//  6. Drop i_wb_cyc with 2 requests in flight -> no ACK afterwards.
//     Assert i_reset_n=0 mid-burst -> all outputs 0 immediately, without
//     waiting for a clock edge.

Source files
------------

// File: rtl/wb_ram_model.sv
// Pipelined Wishbone B4 slave memory model: fixed-latency ACK/ERR responses,
// byte-lane writes, and optional LFSR-driven stall insertion.
module wb_ram_model #(
  parameter int AW        = 5,
  parameter int DW        = 32,
  parameter int MEMWORDS  = 24,
  parameter int LATENCY   = 2,
  parameter bit OPT_STALL = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_wb_cyc,
  input  logic            i_wb_stb,
  input  logic            i_wb_we,
  input  logic [AW-1:0]   i_wb_addr,
  input  logic [DW-1:0]   i_wb_data,
  input  logic [DW/8-1:0] i_wb_sel,
  output logic            o_wb_stall,
  output logic            o_wb_ack,
  output logic [DW-1:0]   o_wb_data,
  output logic            o_wb_err
);

  localparam int NB = DW / 8;

  logic [15:0]         lfsr;
  logic                lfsr_fb;
  logic                accept;
  logic                req_err;
  logic [DW-1:0]       mem [MEMWORDS];
  logic [LATENCY-1:0]  vld;
  logic [LATENCY-1:0]  we_q;
  logic [LATENCY-1:0]  err_q;
  logic [DW-1:0]       rdata_q [LATENCY];

  // Fibonacci taps 16,14,13,11.
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign accept  = i_wb_cyc & i_wb_stb & ~o_wb_stall;
  assign req_err = (int'(i_wb_addr) >= MEMWORDS);

  // NOTE: non-blocking assignments make the stall use the pre-advance LFSR value.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      lfsr       <= 16'hACE1;
      o_wb_stall <= 1'b0;
    end else begin
      lfsr       <= {lfsr[14:0], lfsr_fb};
      o_wb_stall <= OPT_STALL & lfsr[0] & lfsr[1];
    end
  end

  // NOTE: memory has no reset so it maps to plain RAM; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (accept && i_wb_we && !req_err) begin
      for (int k = 0; k < NB; k++) begin
        if (i_wb_sel[k]) mem[i_wb_addr][8*k +: 8] <= i_wb_data[8*k +: 8];
      end
    end
  end

  // Payload only matters where vld is set, so it shifts unconditionally.
  always_ff @(posedge i_clk) begin
    we_q[0]    <= i_wb_we;
    err_q[0]   <= req_err;
    rdata_q[0] <= (!i_wb_we && !req_err) ? mem[i_wb_addr] : '0;
    for (int i = 1; i < LATENCY; i++) begin
      we_q[i]    <= we_q[i-1];
      err_q[i]   <= err_q[i-1];
      rdata_q[i] <= rdata_q[i-1];
    end
  end

  // Dropping cyc flushes every in-flight request and blocks the next response.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      vld       <= '0;
      o_wb_ack  <= 1'b0;
      o_wb_err  <= 1'b0;
      o_wb_data <= '0;
    end else begin
      vld[0] <= accept;
      for (int i = 1; i < LATENCY; i++) begin
        vld[i] <= vld[i-1] & i_wb_cyc;
      end
      o_wb_ack  <= i_wb_cyc & vld[LATENCY-1] & ~err_q[LATENCY-1];
      o_wb_err  <= i_wb_cyc & vld[LATENCY-1] &  err_q[LATENCY-1];
      o_wb_data <= (i_wb_cyc && vld[LATENCY-1] && !we_q[LATENCY-1] && !err_q[LATENCY-1])
                   ? rdata_q[LATENCY-1] : '0;
    end
  end

endmodule

// File: tb/tb_wb_ram_model.sv
// Self-checking bench for wb_ram_model: scoreboard of expected responses,
// one no-stall instance and one LFSR-stall instance sharing a bus driver.
module tb_wb_ram_model;

  localparam int AW       = 5;
  localparam int DW       = 32;
  localparam int NB       = DW / 8;
  localparam int MEMWORDS = 24;
  localparam int LAT      = 2;

  typedef struct {
    logic          err;
    logic [DW-1:0] data;
    int            t;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cyc = 1'b0, stb = 1'b0, we = 1'b0, sel_b = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [NB-1:0] bsel = '0;

  logic          cyc_a, stb_a, cyc_b, stb_b;
  logic          stall_a, ack_a, err_a, stall_b, ack_b, err_b;
  logic [DW-1:0] data_a, data_b;
  logic          stall_m, ack_m, err_m;
  logic [DW-1:0] data_m;

  int n_cmp = 0, n_bad = 0, n_acc = 0, n_resp = 0, n_err = 0, n_stalls = 0;
  int cyc_cnt = 0;
  logic [DW-1:0] last_data = '0;
  exp_t q[$];
  exp_t e;
  logic [DW-1:0] model [2][MEMWORDS];
  logic [15:0] m_lfsr;
  logic        m_stall;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  assign cyc_a   = cyc & ~sel_b;
  assign stb_a   = stb & ~sel_b;
  assign cyc_b   = cyc & sel_b;
  assign stb_b   = stb & sel_b;
  assign stall_m = sel_b ? stall_b : stall_a;
  assign ack_m   = sel_b ? ack_b   : ack_a;
  assign err_m   = sel_b ? err_b   : err_a;
  assign data_m  = sel_b ? data_b  : data_a;

  wb_ram_model #(.AW(AW), .DW(DW), .MEMWORDS(MEMWORDS), .LATENCY(LAT), .OPT_STALL(1'b0)) dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc_a), .i_wb_stb(stb_a), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(bsel),
    .o_wb_stall(stall_a), .o_wb_ack(ack_a), .o_wb_data(data_a), .o_wb_err(err_a));

  wb_ram_model #(.AW(AW), .DW(DW), .MEMWORDS(MEMWORDS), .LATENCY(LAT), .OPT_STALL(1'b1)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc_b), .i_wb_stb(stb_b), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(bsel),
    .o_wb_stall(stall_b), .o_wb_ack(ack_b), .o_wb_data(data_b), .o_wb_err(err_b));

  // Reference stall sequence: registered lfsr[0]&lfsr[1], taps 16,14,13,11.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr  <= 16'hACE1;
      m_stall <= 1'b0;
    end else begin
      m_stall <= m_lfsr[0] & m_lfsr[1];
      m_lfsr  <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  // Response monitor: pops the scoreboard on every ACK/ERR.
  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      if (stall_b !== m_stall) begin
        n_bad++;
        $display("FAIL stall_lfsr cyc=%0d got=%b exp=%b", cyc_cnt, stall_b, m_stall);
      end
      n_cmp++;
      if (stall_a !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_disabled cyc=%0d got=%b exp=0", cyc_cnt, stall_a);
      end
      if (ack_m === 1'b1 || err_m === 1'b1) begin
        n_resp++;
        if (err_m === 1'b1) n_err++;
        last_data = data_m;
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_rsp cyc=%0d ack=%b err=%b exp=none", cyc_cnt, ack_m, err_m);
        end else begin
          e = q.pop_front();
          if ({ack_m, err_m} !== {~e.err, e.err} || data_m !== e.data || cyc_cnt != e.t + LAT) begin
            n_bad++;
            $display("FAIL response cyc=%0d got ack=%b err=%b data=%h exp ack=%b err=%b data=%h cyc=%0d",
                     cyc_cnt, ack_m, err_m, data_m, ~e.err, e.err, e.data, e.t + LAT);
          end
        end
      end else begin
        n_cmp++;
        if (ack_m !== 1'b0 || err_m !== 1'b0 || data_m !== '0) begin
          n_bad++;
          $display("FAIL idle_outputs cyc=%0d got ack=%b err=%b data=%h exp 0/0/0",
                   cyc_cnt, ack_m, err_m, data_m);
        end
      end
    end
  end

  // Drive one request and hold it until accepted; push its expected response.
  task automatic bus_req(input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [NB-1:0] s);
    exp_t x;
    logic stalled;
    int   tries = 0;
    bit   done = 0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; bsel = s;
    while (!done) begin
      stalled = stall_m;
      @(posedge clk);
      #1;
      if (!stalled) begin
        done = 1;
        n_acc++;
        x.err  = (int'(a) >= MEMWORDS);
        x.t    = cyc_cnt;
        x.data = '0;
        if (!x.err) begin
          if (w) begin
            for (int k = 0; k < NB; k++)
              if (s[k]) model[sel_b][a][8*k +: 8] = d[8*k +: 8];
          end else begin
            x.data = model[sel_b][a];
          end
        end
        q.push_back(x);
      end else begin
        n_stalls++;
        tries++;
        if (tries > 50) begin
          n_cmp++; n_bad++;
          $display("FAIL accept_timeout addr=%0d got stalled exp accepted", a);
          done = 1;
        end else begin
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic bus_end();
    @(negedge clk);
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic drain(output bit ok);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({ack_a, err_a, stall_a, data_a, ack_b, err_b, stall_b, data_b} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got a=%b%b%b/%h b=%b%b%b/%h exp all 0",
               ack_a, err_a, stall_a, data_a, ack_b, err_b, stall_b, data_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_read();
    bit ok;
    int r0 = n_resp;
    sel_b = 1'b0;
    bus_req(1'b1, 5'd3, 32'h1234_5678, 4'hf);
    bus_req(1'b0, 5'd3, 32'h0, 4'h0);
    bus_end();
    drain(ok);
    n_cmp++;
    if (!ok || n_resp - r0 != 2 || last_data !== 32'h1234_5678) begin
      n_bad++;
      $display("FAIL write_read got rsp=%0d data=%h drained=%0d exp rsp=2 data=12345678 drained=1",
               n_resp - r0, last_data, ok);
    end
  endtask

  task automatic test_byte_lanes();
    bit ok;
    bus_req(1'b1, 5'd5, 32'hFFFF_FFFF, 4'hf);
    bus_req(1'b1, 5'd5, 32'h0000_00AA, 4'b0001);
    bus_req(1'b0, 5'd5, 32'h0, 4'h0);
    bus_end();
    drain(ok);
    n_cmp++;
    if (!ok || last_data !== 32'hFFFF_FFAA) begin
      n_bad++;
      $display("FAIL byte_lanes got data=%h drained=%0d exp data=ffffffaa drained=1", last_data, ok);
    end
  endtask

  task automatic test_burst();
    bit ok;
    int r0 = n_resp;
    int s0 = n_stalls;
    for (int i = 0; i < 8; i++)
      bus_req(1'b1, AW'(i), 32'hA500_0000 | (i * 32'h0001_0101), 4'hf);
    for (int i = 0; i < 8; i++)
      bus_req(1'b0, AW'(i), 32'h0, 4'h0);
    bus_end();
    drain(ok);
    n_cmp++;
    if (!ok || n_resp - r0 != 16 || n_stalls != s0) begin
      n_bad++;
      $display("FAIL burst got rsp=%0d stalls=%0d exp rsp=16 stalls=0", n_resp - r0, n_stalls - s0);
    end
  endtask

  task automatic test_out_of_range();
    bit ok;
    int e0;
    bus_req(1'b1, 5'd1, 32'h1111_2222, 4'hf);
    e0 = n_err;
    bus_req(1'b1, 5'd25, 32'hDEAD_BEEF, 4'hf);
    bus_req(1'b0, 5'd25, 32'h0, 4'h0);
    bus_req(1'b0, 5'd1, 32'h0, 4'h0);
    bus_end();
    drain(ok);
    n_cmp++;
    if (!ok || n_err - e0 != 2 || last_data !== 32'h1111_2222) begin
      n_bad++;
      $display("FAIL out_of_range got errs=%0d data@1=%h exp errs=2 data@1=11112222",
               n_err - e0, last_data);
    end
  endtask

  task automatic test_random_stall();
    bit ok;
    int r0, a0, s0;
    sel_b = 1'b1;
    r0 = n_resp; a0 = n_acc; s0 = n_stalls;
    for (int i = 0; i < MEMWORDS; i++)
      bus_req(1'b1, AW'(i), $urandom, 4'hf);
    for (int i = 0; i < 64; i++)
      bus_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, 27)), $urandom,
              NB'($urandom_range(0, 15)));
    bus_end();
    drain(ok);
    n_cmp++;
    if (!ok || n_resp - r0 != n_acc - a0) begin
      n_bad++;
      $display("FAIL random_stall got rsp=%0d exp rsp=%0d (accepts)", n_resp - r0, n_acc - a0);
    end
    n_cmp++;
    if (n_stalls == s0) begin
      n_bad++;
      $display("FAIL stall_seen got stalls=0 exp stalls>0");
    end
    @(negedge clk);
    cyc = 1'b0;
    sel_b = 1'b0;
  endtask

  task automatic test_abort();
    int r0 = n_resp;
    bus_req(1'b0, 5'd3, 32'h0, 4'h0);
    bus_req(1'b0, 5'd5, 32'h0, 4'h0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    q.delete();
    repeat (5) @(negedge clk);
    #1;
    n_cmp++;
    if (n_resp != r0) begin
      n_bad++;
      $display("FAIL abort got rsp=%0d exp rsp=0", n_resp - r0);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [DW-1:0] exp_rd = model[0][3];
    bus_req(1'b0, 5'd3, 32'h0, 4'h0);
    bus_req(1'b0, 5'd5, 32'h0, 4'h0);
    bus_req(1'b0, 5'd0, 32'h0, 4'h0);
    n_cmp++;
    if (ack_a !== 1'b1 || data_a !== exp_rd) begin
      n_bad++;
      $display("FAIL pre_reset_ack got ack=%b data=%h exp ack=1 data=%h", ack_a, data_a, exp_rd);
    end
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    n_cmp++;
    if ({ack_a, err_a, stall_a, data_a, ack_b, err_b, stall_b, data_b} !== '0) begin
      n_bad++;
      $display("FAIL async_reset got a=%b%b%b/%h b=%b%b%b/%h exp all 0",
               ack_a, err_a, stall_a, data_a, ack_b, err_b, stall_b, data_b);
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_burst();
    test_out_of_range();
    test_random_stall();
    test_abort();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
